// File: rtl/multiword_add_sequencer_pkg.sv
// multiword_add_sequencer_pkg: FSM state encoding and index-width helper shared by the adder sequencer
package multiword_add_sequencer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: operand request and result handshake bundle
// master: producer/consumer side (drives in_valid, operands, out_ready)
// slave:  sequencer side (drives in_ready, out_valid, out_sum, out_cout, out_ovf)
interface multiword_add_sequencer_if #(
    parameter int CHUNK = 8,
    parameter int WORDS = 4
);
    localparam int W = CHUNK * WORDS;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    modport master (
        output in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
    modport slave (
        input  in_valid, in_x, in_y, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/multiword_add_sequencer_add_slice.sv
// add_slice: combinational CHUNK-bit ripple adder, LSB to MSB
// a, b: addends; cin: carry in; sum: result; cout: carry out of MSB;
// msb_cin: carry into the MSB, used for signed overflow detection
module add_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);
    logic [CHUNK:0] c;
    always_comb begin
        c = '0;
        sum = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end
    assign cout = c[CHUNK];
    assign msb_cin = c[CHUNK-1];
endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: adds/subtracts two WORDS*CHUNK-bit operands one chunk per clock on a shared slice
// clk1: clock; rst: async active-high reset; bus: slave side of the request/result handshake
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int WORDS = 4
) (
    input logic clk1,
    input logic rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int W = CHUNK * WORDS;
    localparam int IW = (WORDS > 1) ? clog2(WORDS) : 1;
    state_t state, next_state;
    logic [IW-1:0] idx;
    logic carry, cout, ovf;
    logic [W-1:0] x, y, sum;
    logic [CHUNK-1:0] s_sum;
    logic s_cout, s_msb_cin, last;
    assign last = idx == IW'(WORDS - 1);
    add_slice #(.CHUNK(CHUNK)) u_slice (
        .a(x[idx*CHUNK +: CHUNK]),
        .b(y[idx*CHUNK +: CHUNK]),
        .cin(carry),
        .sum(s_sum),
        .cout(s_cout),
        .msb_cin(s_msb_cin)
    );
    always_ff @(posedge clk1 or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;
    always_comb
        next_state = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                     state == RUN  ? (last ? HOLD : RUN) :
                     state == HOLD ? (bus.out_ready ? IDLE : HOLD) : IDLE;
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.out_valid = state == HOLD;
        bus.out_sum = sum;
        bus.out_cout = cout;
        bus.out_ovf = ovf;
    end
    // Subtraction is folded into the add: Y is inverted once at acceptance and the carry seeded with 1.
    always_ff @(posedge clk1 or posedge rst)
        if (rst) begin
            idx <= '0;
            carry <= 1'b0;
            x <= '0;
            y <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            x <= bus.in_x;
            y <= bus.in_sub ? ~bus.in_y : bus.in_y;
            carry <= bus.in_sub | bus.in_cin;
            idx <= '0;
        end else if (state == RUN) begin
            sum[idx*CHUNK +: CHUNK] <= s_sum;
            carry <= s_cout;
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout <= s_cout;
                ovf <= s_cout ^ s_msb_cin;
            end
        end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: randomized and directed checks of the multiword add sequencer against an arithmetic model
module tb_multiword_add_sequencer;
    localparam int CHUNK = 8;
    localparam int WORDS = 4;
    localparam int W = CHUNK * WORDS;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    multiword_add_sequencer_if #(.CHUNK(CHUNK), .WORDS(WORDS)) bus ();
    multiword_add_sequencer #(.CHUNK(CHUNK), .WORDS(WORDS)) dut (
        .clk1(clk),
        .rst(rst),
        .bus(bus)
    );
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                                  input logic sub, output logic [W-1:0] s, output logic co, output logic ov);
        longint ux, uy, sx, sy, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s = sub ? x - y : x + y + W'(cin);
        co = sub ? (ux >= uy) : (ux + uy + longint'(cin) > 64'hFFFF_FFFF);
        sr = sub ? sx - sy : sx + sy + longint'(cin);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction
    task automatic drive_req(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin, input logic sub);
        bus.in_x = x;
        bus.in_y = y;
        bus.in_cin = cin;
        bus.in_sub = sub;
        bus.in_valid = 1'b1;
    endtask
    task automatic wait_result(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic cin, input logic sub);
        logic [W-1:0] es;
        logic ec, eo;
        int cyc;
        model(x, y, cin, sub, es, ec, eo);
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== WORDS + 1) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d want %0d", name, cyc, WORDS + 1);
        end
        checks++;
        if (bus.out_sum !== es || bus.out_cout !== ec || bus.out_ovf !== eo) begin
            errors++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, bus.out_sum, bus.out_cout, bus.out_ovf, es, ec, eo);
        end
    endtask
    task automatic finish_handshake(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic cin, input logic sub);
        drive_req(x, y, cin, sub);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle ready: got %b want 1", name, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x = $urandom;
        bus.in_y = $urandom;
        bus.in_cin = 1'($urandom);
        bus.in_sub = 1'($urandom);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy ready: got %b want 0", name, bus.in_ready);
        end
        wait_result(name, x, y, cin, sub);
        finish_handshake(name);
    endtask
    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
            bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    task automatic test_directed();
        run_op("carry_chunk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("sub_neg", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub_self", 32'hA5C3_0F11, 32'hA5C3_0F11, 1'b1, 1'b1);
    endtask
    task automatic test_random();
        logic [W-1:0] pick [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [W-1:0] x, y;
        for (int i = 0; i < 24; i++) begin
            x = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
            run_op("random", x, y, 1'($urandom), 1'($urandom));
        end
    endtask
    task automatic test_backpressure();
        logic [W-1:0] es;
        logic ec, eo;
        model(32'h0102_03F0, 32'h00FF_0020, 1'b1, 1'b0, es, ec, eo);
        drive_req(32'h0102_03F0, 32'h00FF_0020, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result("bp_first", 32'h0102_03F0, 32'h00FF_0020, 1'b1, 1'b0);
        drive_req(32'hDEAD_BEEF, 32'h1111_0001, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== es ||
                bus.out_cout !== ec || bus.out_ovf !== eo) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h want 1 0 %h", i,
                         bus.out_valid, bus.in_ready, bus.out_sum, es);
            end
        end
        finish_handshake("bp_release");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got in_ready=%b want 0", bus.in_ready);
        end
        wait_result("bp_second", 32'hDEAD_BEEF, 32'h1111_0001, 1'b0, 1'b1);
        finish_handshake("bp_second");
    endtask
    task automatic test_reset_mid_run();
        int seen;
        drive_req(32'hCAFE_F00D, 32'h0F0F_0F0F, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== '0 ||
            bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_valid: got %0d valid cycles want 0", seen);
        end
        run_op("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        checks++;
        if (bus.out_sum !== 32'h2345_6789) begin
            errors++;
            $display("FAIL after_reset_sum: got %h want 23456789", bus.out_sum);
        end
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_y = '0;
        bus.in_cin = 1'b0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
